// File: rtl/exec_mem_unit.sv
// Execute/memory slice: operand forwarding mux, 8-bit ALU with zero/carry flags, 256x8 data memory.
// Latency: ALU result and memory read are combinational; flags and memory writes land on the next clk edge.
// Backpressure: none; the slice accepts one operation every cycle with no stall path.
module exec_mem_unit #(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] id_data_1,
    input  logic [DATA_W-1:0] id_data_2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic              is_shift,
    input  logic [2:0]        shamt,
    input  logic [1:0]        scode,
    input  logic [2:0]        acode,
    input  logic              update_z_c,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_write,
    output logic [DATA_W-1:0] alu_result,
    output logic              alu_carry,
    output logic              zero,
    output logic              carry,
    output logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDC = 3'b001,
        OP_SUB  = 3'b010,
        OP_SUBC = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_MASK = 3'b111
    } acode_e;

    typedef enum logic [1:0] {
        SH_SHL = 2'b00,
        SH_SHR = 2'b01,
        SH_ROL = 2'b10,
        SH_ROR = 2'b11
    } scode_e;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] op_b;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Operand A source; code 11 is unused by the forwarding unit and falls back to the register file.
    always_comb begin
        op_a = id_data_1;
        case (forward_a)
            2'b01:   op_a = ex_result;
            2'b10:   op_a = wb_data;
            default: op_a = id_data_1;
        endcase
    end

    // Operand B source; an immediate overrides whatever forwarding picked.
    always_comb begin
        fwd_b = id_data_2;
        case (forward_b)
            2'b01:   fwd_b = ex_result;
            2'b10:   fwd_b = wb_data;
            default: fwd_b = id_data_2;
        endcase
        op_b = alu_src ? imm : fwd_b;
    end

    // Arithmetic, logic and shift datapath. Carry-in always comes from the registered flag,
    // so ADDC/SUBC see the value from before the current edge.
    logic [DATA_W:0]     sum9;
    logic [DATA_W:0]     diff9;
    logic [DATA_W:0]     b_plus_c9;
    logic [2*DATA_W-1:0] rol_w;
    logic [2*DATA_W-1:0] ror_w;
    logic [2:0]          shl_idx;
    logic [2:0]          shr_idx;

    always_comb begin
        sum9       = '0;
        diff9      = '0;
        b_plus_c9  = {1'b0, op_b} + {{DATA_W{1'b0}}, carry_q};
        rol_w      = {op_a, op_a} << shamt;
        ror_w      = {op_a, op_a} >> shamt;
        // 8-n and n-1 taken modulo 8; only used when n is non-zero.
        shl_idx    = 3'd0 - shamt;
        shr_idx    = shamt - 3'd1;
        alu_result = '0;
        alu_carry  = 1'b0;
        if (is_shift) begin
            case (scode_e'(scode))
                SH_SHL: begin
                    alu_result = op_a << shamt;
                    alu_carry  = (shamt != 3'd0) ? op_a[shl_idx] : 1'b0;
                end
                SH_SHR: begin
                    alu_result = op_a >> shamt;
                    alu_carry  = (shamt != 3'd0) ? op_a[shr_idx] : 1'b0;
                end
                SH_ROL:  alu_result = rol_w[2*DATA_W-1:DATA_W];
                default: alu_result = ror_w[DATA_W-1:0];
            endcase
        end else begin
            case (acode_e'(acode))
                OP_ADD: begin
                    sum9       = {1'b0, op_a} + {1'b0, op_b};
                    alu_result = sum9[DATA_W-1:0];
                    alu_carry  = sum9[DATA_W];
                end
                OP_ADDC: begin
                    sum9       = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, carry_q};
                    alu_result = sum9[DATA_W-1:0];
                    alu_carry  = sum9[DATA_W];
                end
                OP_SUB: begin
                    diff9      = {1'b0, op_a} - {1'b0, op_b};
                    alu_result = diff9[DATA_W-1:0];
                    alu_carry  = (op_a < op_b);
                end
                OP_SUBC: begin
                    diff9      = {1'b0, op_a} - b_plus_c9;
                    alu_result = diff9[DATA_W-1:0];
                    alu_carry  = ({1'b0, op_a} < b_plus_c9);
                end
                OP_AND:  alu_result = op_a & op_b;
                OP_OR:   alu_result = op_a | op_b;
                OP_XOR:  alu_result = op_a ^ op_b;
                default: alu_result = op_a & ~op_b;
            endcase
        end
    end

    // Next flag values: latch only when the instruction asks for it.
    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (update_z_c) begin
            zero_d  = (alu_result == '0);
            carry_d = alu_carry;
        end
    end

    // Flag registers; reset clears them immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Data memory storage; reset wipes every word, which also discards an in-flight write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_q[mem_addr];
    assign zero      = zero_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: forwarding, ALU ops, flags, memory and asynchronous reset.
// Latency: checks combinational outputs 1ns after driving, registered state 1ns after the edge.
// Backpressure: not applicable; stimulus is applied one operation per cycle.
module tb_exec_mem_unit;

    logic       clk;
    logic       rst;
    logic [1:0] forward_a, forward_b;
    logic [7:0] id_data_1, id_data_2, ex_result, wb_data, imm;
    logic       alu_src, is_shift;
    logic [2:0] shamt;
    logic [1:0] scode;
    logic [2:0] acode;
    logic       update_z_c;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_write;
    logic [7:0] alu_result;
    logic       alu_carry, zero, carry;
    logic [7:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    exec_mem_unit dut (
        .clk        (clk),
        .rst        (rst),
        .forward_a  (forward_a),
        .forward_b  (forward_b),
        .id_data_1  (id_data_1),
        .id_data_2  (id_data_2),
        .ex_result  (ex_result),
        .wb_data    (wb_data),
        .imm        (imm),
        .alu_src    (alu_src),
        .is_shift   (is_shift),
        .shamt      (shamt),
        .scode      (scode),
        .acode      (acode),
        .update_z_c (update_z_c),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .zero       (zero),
        .carry      (carry),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-shift ALU op with A from id_data_1 (forward_a=00) and B from imm.
    task automatic alu_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        is_shift  = 1'b0;
        acode     = op;
        forward_a = 2'b00;
        id_data_1 = a;
        alu_src   = 1'b1;
        imm       = b;
        #1;
    endtask

    task automatic sh_op(input logic [1:0] sc, input logic [7:0] a, input logic [2:0] n);
        is_shift  = 1'b1;
        scode     = sc;
        shamt     = n;
        forward_a = 2'b00;
        id_data_1 = a;
        acode     = 3'b010;  // must be ignored
        alu_src   = 1'b1;
        imm       = 8'hFF;
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] exp;
    } logic_vec_t;

    typedef struct {
        logic [1:0] sc;
        logic [7:0] a;
        logic [2:0] n;
        logic [7:0] exp_r;
        logic       exp_c;
    } shift_vec_t;

    initial begin
        logic_vec_t lv [4];
        shift_vec_t sv [6];
        logic [7:0] fwd_exp [4];

        rst = 1'b0;
        forward_a = 2'b00; forward_b = 2'b00;
        id_data_1 = '0; id_data_2 = '0; ex_result = '0; wb_data = '0; imm = '0;
        alu_src = 1'b0; is_shift = 1'b0; shamt = '0; scode = '0; acode = '0;
        update_z_c = 1'b0; mem_addr = '0; mem_wdata = '0; mem_write = 1'b0;

        // 1. Reset state, then ADD FF+01 with flag update.
        #12;
        check("rst_zero", {15'd0, zero}, 16'd0);
        check("rst_carry", {15'd0, carry}, 16'd0);
        mem_addr = 8'h10; #1;
        check("rst_mem10", {8'd0, mem_rdata}, 16'h0000);
        mem_addr = 8'hFF; #1;
        check("rst_memFF", {8'd0, mem_rdata}, 16'h0000);
        rst = 1'b1;
        tick();
        alu_op(3'b000, 8'hFF, 8'h01);
        update_z_c = 1'b1;
        check("add_ff_res", {8'd0, alu_result}, 16'h0000);
        check("add_ff_c", {15'd0, alu_carry}, 16'd1);
        tick();
        update_z_c = 1'b0;
        check("flag_zero_set", {15'd0, zero}, 16'd1);
        check("flag_carry_set", {15'd0, carry}, 16'd1);

        // 2. Carry/borrow arithmetic with carry=1.
        alu_op(3'b001, 8'h10, 8'h20);
        check("addc_res", {8'd0, alu_result}, 16'h0031);
        check("addc_c", {15'd0, alu_carry}, 16'd0);
        alu_op(3'b010, 8'h05, 8'h07);
        check("sub_res", {8'd0, alu_result}, 16'h00FE);
        check("sub_borrow", {15'd0, alu_carry}, 16'd1);
        alu_op(3'b011, 8'h10, 8'h01);
        check("subc_res", {8'd0, alu_result}, 16'h000E);
        check("subc_c", {15'd0, alu_carry}, 16'd0);
        alu_op(3'b011, 8'h01, 8'h00);  // 1 - 0 - 1 = 0, no borrow
        check("subc_edge_res", {8'd0, alu_result}, 16'h0000);
        check("subc_edge_c", {15'd0, alu_carry}, 16'd0);
        alu_op(3'b011, 8'h00, 8'hFF);  // 0 < 0xFF+1 -> borrow
        check("subc_ff_res", {8'd0, alu_result}, 16'h0000);
        check("subc_ff_c", {15'd0, alu_carry}, 16'd1);

        // 3. Forwarding on operand A; B from id_data_2.
        fwd_exp[0] = 8'h15; fwd_exp[1] = 8'h26; fwd_exp[2] = 8'h37; fwd_exp[3] = 8'h15;
        is_shift = 1'b0; acode = 3'b000; alu_src = 1'b0; forward_b = 2'b00;
        id_data_1 = 8'h11; ex_result = 8'h22; wb_data = 8'h33; id_data_2 = 8'h04;
        for (int i = 0; i < 4; i++) begin
            forward_a = 2'(i);
            #1;
            check($sformatf("fwd_a_%0d", i), {8'd0, alu_result}, {8'd0, fwd_exp[i]});
        end
        forward_a = 2'b00; forward_b = 2'b10; #1;
        check("fwd_b_wb", {8'd0, alu_result}, 16'h0044);
        alu_src = 1'b1; imm = 8'h80; #1;
        check("imm_override", {8'd0, alu_result}, 16'h0091);

        // 4. Logic, shift and rotate ops.
        lv[0] = '{3'b100, 8'h30};
        lv[1] = '{3'b101, 8'hFC};
        lv[2] = '{3'b110, 8'hCC};
        lv[3] = '{3'b111, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            alu_op(lv[i].op, 8'hF0, 8'h3C);
            check($sformatf("logic_%0d_res", i), {8'd0, alu_result}, {8'd0, lv[i].exp});
            check($sformatf("logic_%0d_c", i), {15'd0, alu_carry}, 16'd0);
        end
        sv[0] = '{2'b00, 8'h81, 3'd1, 8'h02, 1'b1};
        sv[1] = '{2'b01, 8'h81, 3'd1, 8'h40, 1'b1};
        sv[2] = '{2'b10, 8'h81, 3'd1, 8'h03, 1'b0};
        sv[3] = '{2'b11, 8'h81, 3'd4, 8'h18, 1'b0};
        sv[4] = '{2'b00, 8'h81, 3'd0, 8'h81, 1'b0};
        sv[5] = '{2'b01, 8'h81, 3'd0, 8'h81, 1'b0};
        for (int i = 0; i < 6; i++) begin
            sh_op(sv[i].sc, sv[i].a, sv[i].n);
            check($sformatf("shift_%0d_res", i), {8'd0, alu_result}, {8'd0, sv[i].exp_r});
            check($sformatf("shift_%0d_c", i), {15'd0, alu_carry}, {15'd0, sv[i].exp_c});
        end
        sh_op(2'b00, 8'h20, 3'd3);  // carry = A[5]
        check("shl3_res", {8'd0, alu_result}, 16'h0000);
        check("shl3_c", {15'd0, alu_carry}, 16'd1);
        sh_op(2'b01, 8'h04, 3'd3);  // carry = A[2]
        check("shr3_res", {8'd0, alu_result}, 16'h0000);
        check("shr3_c", {15'd0, alu_carry}, 16'd1);

        // 5. Memory.
        mem_addr = 8'h10; mem_wdata = 8'hA5; mem_write = 1'b1;
        tick();
        mem_addr = 8'hFF; mem_wdata = 8'h5A;
        tick();
        mem_write = 1'b0;
        mem_addr = 8'h10; #1;
        check("mem_rd_10", {8'd0, mem_rdata}, 16'h00A5);
        mem_addr = 8'hFF; #1;
        check("mem_rd_FF", {8'd0, mem_rdata}, 16'h005A);
        mem_addr = 8'h10; mem_wdata = 8'h77; mem_write = 1'b1; #1;
        check("mem_old_before_edge", {8'd0, mem_rdata}, 16'h00A5);
        tick();
        check("mem_new_after_edge", {8'd0, mem_rdata}, 16'h0077);
        mem_write = 1'b0; mem_wdata = 8'h11;
        tick();
        check("mem_no_write", {8'd0, mem_rdata}, 16'h0077);
        mem_addr = 8'hFF; #1;
        check("mem_FF_kept", {8'd0, mem_rdata}, 16'h005A);

        // 6. Flag hold over 3 clocks, then reset mid-write.
        alu_op(3'b000, 8'h01, 8'h01);
        update_z_c = 1'b0;
        repeat (3) tick();
        check("hold_zero", {15'd0, zero}, 16'd1);
        check("hold_carry", {15'd0, carry}, 16'd1);
        mem_addr = 8'h10; mem_wdata = 8'h99; mem_write = 1'b1;
        alu_op(3'b000, 8'hFF, 8'h01);
        update_z_c = 1'b1;
        rst = 1'b0; #1;
        check("arst_mem10", {8'd0, mem_rdata}, 16'h0000);
        check("arst_zero", {15'd0, zero}, 16'd0);
        check("arst_carry", {15'd0, carry}, 16'd0);
        tick();
        check("rst_write_ignored", {8'd0, mem_rdata}, 16'h0000);
        check("rst_flag_ignored", {14'd0, zero, carry}, 16'd0);
        mem_write = 1'b0; update_z_c = 1'b0;
        #2 rst = 1'b1;
        mem_addr = 8'hFF; #1;
        check("post_rst_memFF", {8'd0, mem_rdata}, 16'h0000);
        update_z_c = 1'b1;
        tick();
        update_z_c = 1'b0;
        check("resume_flags", {14'd0, zero, carry}, 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory-stage datapath slice of the 8-bit pipelined processor with 19-bit instructions. It contains three parts:
- an operand forwarding selector;
- an 8-bit ALU with registered zero/carry flags;
- a 256x8 data memory.

It sits between the ID/EX and EX/MEM pipeline registers. The forwarding unit and the pipeline registers are outside this block.

Parameters:
DATA_W, 8, datapath width (fixed; other values unsupported)
MEM_DEPTH, 256, data memory words (address width = 8)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
forward_a  in  2  operand A source select
forward_b  in  2  operand B source select
id_data_1  in  8  register-file operand 1 (ID/EX)
id_data_2  in  8  register-file operand 2 (ID/EX)
ex_result  in  8  ALU result held in EX/MEM
wb_data  in  8  write-back value from MEM/WB
imm  in  8  immediate (inst[7:0])
alu_src  in  1  1: ALU B = imm
is_shift  in  1  1: shift/rotate operation
shamt  in  3  shift amount (inst[7:5])
scode  in  2  shift code
acode  in  3  arithmetic/logic code
update_z_c  in  1  latch flags this cycle
mem_addr  in  8  data memory address
mem_wdata  in  8  data memory write data
mem_write  in  1  1: write at clk edge
alu_result  out  8  combinational ALU result
alu_carry  out  1  combinational carry/borrow
zero  out  1  registered zero flag
carry  out  1  registered carry flag
mem_rdata  out  8  combinational memory read data

Behaviour:
Forwarding:
- opA = id_data_1 when forward_a=00; ex_result when 01; wb_data when 10; id_data_1 when 11.
- fwdB is selected the same way from id_data_2 / ex_result / wb_data using forward_b.
- ALU B = imm if alu_src=1, else fwdB.

ALU (combinational). When is_shift=0, r = result, c = alu_carry:
- 000 ADD: {c,r}=A+B (9-bit sum).
- 001 ADDC: {c,r}=A+B+carry, using the registered carry flag.
- 010 SUB: r=A-B mod 256; c=1 iff A<B (borrow).
- 011 SUBC: r=A-B-carry; c=1 iff A < B+carry, compared with 9-bit precision.
- 100 AND, 101 OR, 110 XOR, 111 MASK (A & ~B): c=0.

ALU when is_shift=1: acode and alu_src are ignored; operand is opA, n=shamt (0..7).
- 00 SHL: r=A<<n; c=A[8-n], or 0 if n=0.
- 01 SHR: r=A>>n (logical); c=A[n-1], or 0 if n=0.
- 10 ROL: rotate left n; c=0.
- 11 ROR: rotate right n; c=0.

Flags:
- On rising clk with update_z_c=1: zero<=(alu_result==0), carry<=alu_carry.
- Otherwise flags hold.
- ADDC/SUBC always use the pre-edge flag value.

Data memory:
- 256x8; mem_rdata = mem[mem_addr], combinational.
- On rising clk with mem_write=1: mem[mem_addr] <= mem_wdata.
- A read of the address being written shows the old data until the edge, the new data after it.

Reset:
- rst=0 immediately forces zero=0, carry=0 and every memory word to 0. mem_rdata reads 0 during reset.
- Writes and flag updates are ignored while rst=0.
- Reset mid-write discards the write.
- Operation resumes at the first rising edge after rst returns to 1.

No internal pipeline registers: results are combinational (0-cycle latency); state is visible one edge later.

Test Plan:
1. Reset, then flags and data: pulse rst=0 -> zero=0, carry=0, mem_rdata=0 at any address. Then ADD A=0xFF, B=0x01, update_z_c=1, one clock -> alu_result=0x00, alu_carry=1; after the edge zero=1, carry=1.
2. Carry/borrow arithmetic: with carry=1, ADDC 0x10+0x20 -> 0x31. SUB 0x05-0x07 -> 0xFE, alu_carry=1. Then SUBC 0x10-0x01 with carry=1 -> 0x0E.
3. Forwarding: id_data_1=0x11, ex_result=0x22, wb_data=0x33, id_data_2=0x04, ADD. forward_a 00/01/10/11 -> 0x15/0x26/0x37/0x15. Then alu_src=1, imm=0x80 -> B overrides forwarding.
4. Logic, shift and rotate ops:
   - AND/OR/XOR/MASK on 0xF0, 0x3C -> 0x30 / 0xFC / 0xCC / 0xC0, alu_carry=0.
   - SHL 0x81 n=1 -> 0x02, c=1.
   - SHR 0x81 n=1 -> 0x40, c=1.
   - ROL 0x81 n=1 -> 0x03.
   - ROR 0x81 n=4 -> 0x18.
   - n=0 -> result unchanged, c=0.
5. Memory: write 0xA5 to 0x10 and 0x5A to 0xFF; read both back. Same-cycle read of 0x10 during a write of 0x77 shows 0xA5 before the edge and 0x77 after it. mem_write=0 leaves contents unchanged.
6. Flag hold and reset mid-write: with update_z_c=0, no flag change across 3 clocks. Assert rst=0 while mem_write=1 -> written word reads 0 and flags are cleared asynchronously, before any edge.
